interval_timer_ctrl: RTL and testbench
======================================

// Module: interval_timer_ctrl
// PURPOSE
//   Sequencer for an N-bit up-counter datapath: accepts timing commands over a
//   valid/ready handshake, enables/clears the counter, compares it against a
//   programmed limit and emits a terminal tick. Supports one-shot and
//   auto-reload (periodic) modes. Sits between control logic and any block
//   needing timed events.
// PARAMETERS
//   CNT_W     3   counter/limit width in bits (>=1)
//   PRESCALE  4   cycles per count step when prescaler compiled in (>=2)
// PORTS
//   clk             in   1      clock, rising edge
//   reset_i         in   1      asynchronous, active-high reset
//   cmd_valid_i     in   1      command offered
//   cmd_ready_o     out  1      controller can accept command (IDLE only)
//   cmd_limit_i     in   CNT_W  terminal count value
//   cmd_periodic_i  in   1      1 = auto-reload, 0 = one-shot
//   stop_i          in   1      abort running sequence
//   count_o         out  CNT_W  current counter value
//   busy_o          out  1      1 while in RUN
//   tick_o          out  1      one-cycle pulse at terminal count
// BEHAVIOUR
//   - Reset (async, reset_i=1): state=IDLE, count_o=0, tick_o=0, busy_o=0,
//     cmd_ready_o=1, latched limit/mode=0, prescale counter=0.
//   - States: IDLE, RUN. cmd_ready_o = (state==IDLE); busy_o = (state==RUN).
//     Both are combinational decodes of the state register.
//   - IDLE: on cmd_valid_i & cmd_ready_o, latch limit_q=cmd_limit_i and
//     per_q=cmd_periodic_i, clear count_o to 0, go to RUN next edge.
//   - RUN, step strobe (every cycle; see CONFIGURATION):
//       count_o != limit_q -> count_o <= count_o + 1 (CNT_W bits, no carry out)
//       count_o == limit_q -> count_o <= 0, tick_o <= 1 for exactly one cycle;
//                             per_q=1 stay RUN, per_q=0 go IDLE.
//   - Period = limit_q+1 steps. limit 0 -> tick on first step (every step if periodic).
//   - limit = 2^CNT_W-1: count reaches all-ones, then terminal; never wraps
//     through the adder.
//   - stop_i in RUN: next edge -> IDLE, count_o<=0, no tick. Stop beats
//     terminal in the same cycle. stop_i in IDLE is ignored and does not
//     block acceptance.
//   - tick_o is registered; deasserts on the next edge unless re-triggered.
//   - Commands presented during RUN are not accepted (ready=0) and must be held.
//   - reset_i mid-RUN: immediate return to reset values; no tick emitted.
// CONFIGURATION
//   INTERVAL_TIMER_PRESCALE_EN defined: internal prescale counter
//     ($clog2(PRESCALE) bits) runs in RUN and raises the step strobe once every
//     PRESCALE cycles. It clears on command acceptance, on stop, and on leaving
//     RUN. The first step occurs PRESCALE cycles after entering RUN.
//   Not defined: step strobe = 1 on every RUN cycle; no prescale logic.
//   Ports and state encoding are identical in both builds.
// TESTING (no prescaler unless stated; CNT_W=3)
//   1 reset: assert reset_i mid-run -> count_o=0, tick_o=0, busy_o=0, ready=1
//     immediately (asynchronous).
//   2 one-shot limit=3 -> count_o 0,1,2,3,0; tick_o high 1 cycle after count=3;
//     busy_o falls with tick; ready=1 again.
//   3 periodic limit=7 for 20 cycles -> tick every 8 cycles; count wraps 7->0;
//     count_o never exceeds 7.
//   4 periodic limit=0 -> tick_o high every RUN cycle; stop_i -> IDLE, tick stops.
//   5 stop_i asserted in the cycle count==limit -> no tick, IDLE, count_o=0;
//     cmd_valid_i during RUN held until ready=1, then accepted once.
//   6 INTERVAL_TIMER_PRESCALE_EN, PRESCALE=4, one-shot limit=2 -> count changes
//     every 4 cycles; tick 12 cycles after entering RUN.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: command-driven interval timer sequencer.
// Accepts {limit, periodic} commands over a valid/ready handshake in IDLE.
// In RUN it counts 0..limit, then emits a one-cycle tick, and either
// reloads (periodic) or returns to IDLE (one-shot). stop_i aborts silently.
// Optional build macro INTERVAL_TIMER_PRESCALE_EN slows the count step to
// once every PRESCALE cycles; ports and state encoding are unchanged.
module interval_timer_ctrl #(
  parameter int CNT_W    = 3,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CNT_W-1:0] cmd_limit_i,
  input  logic             cmd_periodic_i,
  input  logic             stop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             tick_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Reject parameter values the datapath cannot represent.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("PRESCALE must be at least 2");
  end

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] limit_reg, limit_next;
  logic             per_reg, per_next;
  logic             tick_reg, tick_next;
  logic             accept;
  logic             step;
  logic             terminal;

  assign accept   = cmd_valid_i && (state_reg == IDLE);
  // Stop has priority over reaching the terminal count.
  assign terminal = (state_reg == RUN) && !stop_i && step && (count_reg == limit_reg);

`ifdef INTERVAL_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_reg, pre_next;

  // The strobe fires on the last cycle of each PRESCALE-long window, so the
  // first step lands PRESCALE cycles after entering RUN.
  assign step = (pre_reg == PRE_LAST);

  // Prescale counter runs only while staying in RUN; otherwise it clears.
  always_comb begin
    pre_next = '0;
    if (state_reg == RUN && state_next == RUN && !stop_i) begin
      pre_next = (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) pre_reg <= '0;
    else         pre_reg <= pre_next;
  end
`else
  assign step = 1'b1;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      count_reg <= '0;
      limit_reg <= '0;
      per_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      limit_reg <= limit_next;
      per_reg   <= per_next;
      tick_reg  <= tick_next;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (stop_i)                     state_next = IDLE;
        else if (terminal && !per_reg)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath updates and status decodes.
  always_comb begin
    count_next  = count_reg;
    limit_next  = limit_reg;
    per_next    = per_reg;
    tick_next   = 1'b0;
    cmd_ready_o = (state_reg == IDLE);
    busy_o      = (state_reg == RUN);
    if (accept) begin
      limit_next = cmd_limit_i;
      per_next   = cmd_periodic_i;
      count_next = '0;
    end else if (state_reg == RUN) begin
      if (stop_i) begin
        count_next = '0;
      end else if (terminal) begin
        // Terminal is detected by compare, so the adder never wraps.
        count_next = '0;
        tick_next  = 1'b1;
      end else if (step) begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  assign count_o = count_reg;
  assign tick_o  = tick_reg;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: directed literal checks plus randomized traffic
// compared each cycle against a cycle-count based behavioural model.
// Honours INTERVAL_TIMER_PRESCALE_EN (PRESCALE=4) the same way as the DUT.
module tb_interval_timer_ctrl;

  localparam int CNT_W = 3;
`ifdef INTERVAL_TIMER_PRESCALE_EN
  localparam int P_STEP = 4;
`else
  localparam int P_STEP = 1;
`endif

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [CNT_W-1:0] cmd_limit_i = '0;
  logic             cmd_periodic_i = 1'b0;
  logic             stop_i = 1'b0;
  logic [CNT_W-1:0] count_o;
  logic             busy_o;
  logic             tick_o;

  int n_checks = 0;
  int n_fail   = 0;

  interval_timer_ctrl #(.CNT_W(CNT_W), .PRESCALE(4)) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_limit_i    (cmd_limit_i),
    .cmd_periodic_i (cmd_periodic_i),
    .stop_i         (stop_i),
    .count_o        (count_o),
    .busy_o         (busy_o),
    .tick_o         (tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a running sequence is described only by the number of cycles k
  // spent in RUN; the count is (k / P_STEP) mod (limit + 1).
  typedef struct {
    bit run;
    int lim;
    bit per;
    int k;
    bit tick;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t s, bit v, int l, bit p, bit st);
    model_t n;
    n = s;
    n.tick = 1'b0;
    if (!s.run) begin
      if (v) begin
        n.run = 1'b1; n.lim = l; n.per = p; n.k = 0;
      end
    end else if (st) begin
      n.run = 1'b0; n.k = 0;
    end else begin
      n.k = s.k + 1;
      if ((n.k % P_STEP) == 0 && ((n.k / P_STEP) % (s.lim + 1)) == 0) begin
        n.tick = 1'b1;
        if (!s.per) begin
          n.run = 1'b0; n.k = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic int model_count(model_t s);
    return s.run ? (s.k / P_STEP) % (s.lim + 1) : 0;
  endfunction

  // Advance the model on each clock edge; reset mirrors the async reset.
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) m <= '{run: 1'b0, lim: 0, per: 1'b0, k: 0, tick: 1'b0};
    else         m <= model_step(m, cmd_valid_i, int'(cmd_limit_i), cmd_periodic_i, stop_i);
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (!reset_i) begin
      check("model_count", int'(count_o), model_count(m));
      check("model_tick",  int'(tick_o), int'(m.tick));
      check("model_busy",  int'(busy_o), int'(m.run));
      check("model_ready", int'(cmd_ready_o), int'(!m.run));
    end
  end

  task automatic send(input int lim, input bit per);
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_limit_i = CNT_W'(lim); cmd_periodic_i = per;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    bit acc_pending;
    #2;
    check("reset_count", int'(count_o), 0);
    check("reset_busy",  int'(busy_o), 0);
    check("reset_ready", int'(cmd_ready_o), 1);
    check("reset_tick",  int'(tick_o), 0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;

`ifdef INTERVAL_TIMER_PRESCALE_EN
    begin
      int exp_cnt [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
      send(2, 1'b0);
      check("pre_idx0_busy", int'(busy_o), 1);
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        check($sformatf("pre_count_%0d", i), int'(count_o), exp_cnt[i]);
        check($sformatf("pre_tick_%0d", i), int'(tick_o), (i == 12) ? 1 : 0);
      end
      check("pre_end_busy", int'(busy_o), 0);
    end
`else
    // One-shot limit 3.
    send(3, 1'b0);
    check("os_idx0_count", int'(count_o), 0);
    check("os_idx0_busy",  int'(busy_o), 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("os_count_%0d", i), int'(count_o), i);
      check($sformatf("os_tick_%0d", i), int'(tick_o), 0);
    end
    @(negedge clk);
    check("os_tick",  int'(tick_o), 1);
    check("os_busy",  int'(busy_o), 0);
    check("os_ready", int'(cmd_ready_o), 1);
    check("os_count", int'(count_o), 0);
    @(negedge clk);
    check("os_tick_off", int'(tick_o), 0);

    // Periodic limit 7 (all-ones).
    send(7, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("per7_tick_%0d", i), int'(tick_o), (i % 8 == 0) ? 1 : 0);
      check($sformatf("per7_count_%0d", i), int'(count_o), i % 8);
    end
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("per7_stop_busy", int'(busy_o), 0);

    // Periodic limit 0.
    send(0, 1'b1);
    check("per0_idx0_tick", int'(tick_o), 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("per0_tick_%0d", i), int'(tick_o), 1);
      check($sformatf("per0_busy_%0d", i), int'(busy_o), 1);
    end
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("per0_stop_tick", int'(tick_o), 0);
    check("per0_stop_busy", int'(busy_o), 0);
    @(negedge clk);
    check("per0_after_tick", int'(tick_o), 0);

    // Stop on the terminal cycle.
    send(2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("stopterm_count2", int'(count_o), 2);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("stopterm_tick",  int'(tick_o), 0);
    check("stopterm_busy",  int'(busy_o), 0);
    check("stopterm_count", int'(count_o), 0);

    // Command held during RUN, accepted once after a stop.
    send(5, 1'b1);
    cmd_valid_i = 1'b1; cmd_limit_i = 3'd2; cmd_periodic_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold_ready_%0d", i), int'(cmd_ready_o), 0);
    end
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("hold_idle_ready", int'(cmd_ready_o), 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("hold_acc_busy",  int'(busy_o), 1);
    check("hold_acc_count", int'(count_o), 0);
    @(negedge clk); check("hold_count1", int'(count_o), 1);
    @(negedge clk); check("hold_count2", int'(count_o), 2);
    @(negedge clk); check("hold_tick",   int'(tick_o), 1);
    repeat (3) @(negedge clk);
    check("hold_once_busy", int'(busy_o), 0);
`endif

    // Asynchronous reset in the middle of a periodic run.
    send(5, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_i = 1'b1;
    #1;
    check("areset_count", int'(count_o), 0);
    check("areset_tick",  int'(tick_o), 0);
    check("areset_busy",  int'(busy_o), 0);
    check("areset_ready", int'(cmd_ready_o), 1);
    @(negedge clk);
    reset_i = 1'b0;

    // Randomized traffic; a command is held until it is accepted.
    acc_pending = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (acc_pending || !cmd_valid_i) begin
        cmd_valid_i    = ($urandom_range(0, 2) == 0);
        cmd_limit_i    = CNT_W'($urandom_range(0, 7));
        cmd_periodic_i = $urandom_range(0, 1) == 1;
      end
      stop_i = ($urandom_range(0, 15) == 0);
      acc_pending = cmd_valid_i && cmd_ready_o;
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    stop_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
